led_blink_ctrl: RTL and testbench
=================================

Name: led_blink_ctrl

Overview:
- Downstream consumer of the LED peripheral's AXI4-Lite register block.
- Takes per-LED commands written by software (off / on / blink with on- and off-durations in 10 ms units, IPMI FRU-LED style) and drives the physical front-panel LED pins.
- Holds per-LED state machines and a shared 10 ms timebase.
- Reports each LED's current state back to the register block for readback.

Parameters:
- NUM_LEDS, 4, number of LED channels (1..16).
- TICK_DIV, 500000, ACLK cycles per 10 ms tick (50 MHz clock).
- ACTIVE_LOW, 0, 1 = led_o pins are driven inverted.

Ports:
- ACLK  in  1  single clock for all logic.
- ARESETN  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_led  in  4  target LED index.
- cmd_mode  in  2  00 OFF, 01 ON, 10 BLINK, 11 reserved.
- cmd_on_time  in  8  BLINK on-duration, in ticks.
- cmd_off_time  in  8  BLINK off-duration, in ticks.
- cmd_err  out  1  one-cycle pulse when a command is rejected.
- led_o  out  NUM_LEDS  LED pins, polarity per ACTIVE_LOW.
- led_state_o  out  2*NUM_LEDS  per-LED state code for readback, LED i at bits [2i+1:2i].

Behaviour:
- Clock and reset: one clock, ACLK. Reset ARESETN is asynchronous and active-low.
- Reset values:
  - All LEDs in OFF state.
  - Logical led value 0 (pins = ACTIVE_LOW).
  - led_state_o = 0, cmd_ready = 0, cmd_err = 0.
  - Prescaler = 0.
- cmd_ready: goes 1 on the first ACLK edge after reset release, then stays 1.
- Command acceptance: a command is accepted on a cycle with cmd_valid && cmd_ready.
- Command rejection: if cmd_led >= NUM_LEDS or cmd_mode == 11, the command is dropped and cmd_err pulses on the next cycle. No LED changes.
- Tick generator: prescaler counts 0..TICK_DIV-1; tick is asserted for one cycle when the count wraps. The prescaler is free-running and is not restarted by commands.
- Per-LED FSM states (led_state_o code): OFF=0, ON=1, BLK_ON=2, BLK_OFF=3.
- Each LED has an 8-bit down-counter cnt plus latched on_t and off_t.
- Command effect: takes effect the cycle after acceptance and overrides any state immediately, mid-blink included.
  - OFF → state OFF.
  - ON → state ON.
  - BLINK with on_time==0 → state OFF.
  - BLINK with on_time!=0 and off_time==0 → state ON.
  - Otherwise → state BLK_ON, with cnt=on_time.
- BLK_ON, on tick:
  - If cnt==1: go to BLK_OFF, load cnt=off_t.
  - Else: decrement cnt.
- BLK_OFF: symmetric, returning to BLK_ON and loading cnt=on_t.
- Phase timing: the first phase after a command lasts (on_time-1, on_time] ticks; every later phase is exact.
- LED output: led logical = 1 in ON and BLK_ON. Registered; led_o changes one cycle after the state changes.
- Simultaneous tick and command to the same LED: the command wins.
- Tick on one LED and a command to another LED in the same cycle: both take effect.
- Reset asserted mid-blink: immediate return to reset values (asynchronous).

Optional Feature:
- Macro: LED_LAMP_TEST_EN.
- With the macro defined, adds these ports:
  - lamp_test_start  in  1
  - lamp_test_dur  in  8  (units of 10 ticks)
  - lamp_test_active  out  1
- Lamp-test behaviour:
  - A start pulse loads a 12-bit counter with lamp_test_dur*10.
  - While the counter is non-zero, all led_o are forced on; the counter decrements per tick.
  - The per-LED FSMs keep running underneath. When the counter reaches 0, outputs resume from the FSMs.
  - A start pulse during an active test reloads the counter.
  - A start pulse with dur=0 is ignored.
- Without the macro: no lamp-test ports, no extra logic.

Decomposition:
- Package led_ctrl_pkg: state encoding constants (OFF/ON/BLK_ON/BLK_OFF), mode codes, the 8-bit duration width, and the lamp-test multiplier 10.
- Sub-module led_tick_gen: parameter TICK_DIV, ports ACLK, ARESETN, tick.
- The per-LED FSM is generated with a loop, not a separate module.

Test Plan:
- Bench parameters: TICK_DIV=4, NUM_LEDS=4, ACTIVE_LOW=0.
1. Reset check: hold ARESETN=0 then release → led_o=0, led_state_o=0, cmd_ready=1 one cycle after release.
2. ON/OFF: cmd led=2 mode=01 → led_o[2]=1 two cycles after acceptance, state code 1. Then mode=00 → led_o[2]=0.
3. BLINK: led=0, on=3, off=2, accepted right after a tick → led_o[0] high 12 cycles, low 8 cycles, repeating for 5 periods. State codes alternate 2/3.
4. Degenerate and illegal commands:
   - BLINK on=0 → OFF.
   - BLINK on=5 off=0 → ON.
   - cmd_led=7 → cmd_err pulse, no LED change.
   - mode=11 → cmd_err pulse, no LED change.
5. Override and reset: re-command led 0 to ON mid-BLK_OFF → led high the next cycle. Assert ARESETN mid-blink → all outputs 0 asynchronously, before the next ACLK edge.
6. Lamp test (LED_LAMP_TEST_EN): dur=1 with LEDs in mixed states → all led_o=1 for 10 ticks (40 cycles), lamp_test_active high, then prior FSM outputs resume.

Source files
------------

// File: rtl/led_ctrl_pkg.sv
// Shared encodings and widths for the LED blink controller.
// Optional lamp test is enabled with `define LED_LAMP_TEST_EN.
package led_ctrl_pkg;
  localparam int DUR_W     = 8;
  localparam int LAMP_W    = 12;
  localparam int LAMP_MULT = 10;

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_ON      = 2'd1,
    ST_BLK_ON  = 2'd2,
    ST_BLK_OFF = 2'd3
  } led_st_e;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_RSVD  = 2'd3
  } led_mode_e;
endpackage

// File: rtl/led_tick_gen.sv
// Free-running prescaler; tick is high during the last count before wrap.
module led_tick_gen #(
  parameter int TICK_DIV = 500000
) (
  input  logic ACLK,
  input  logic ARESETN,
  output logic tick
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] pre_q, pre_d;

  assign tick = (pre_q == CW'(TICK_DIV - 1));

  always_comb begin
    pre_d = tick ? '0 : pre_q + CW'(1);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) pre_q <= '0;
    else          pre_q <= pre_d;
  end
endmodule

// File: rtl/led_blink_ctrl.sv
// Per-LED off/on/blink FSMs driven by software commands and a shared 10 ms tick.
// `define LED_LAMP_TEST_EN adds a timed force-all-on lamp test.
module led_blink_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int NUM_LEDS   = 4,
  parameter int TICK_DIV   = 500000,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [3:0]            cmd_led,
  input  logic [1:0]            cmd_mode,
  input  logic [DUR_W-1:0]      cmd_on_time,
  input  logic [DUR_W-1:0]      cmd_off_time,
  output logic                  cmd_err,
`ifdef LED_LAMP_TEST_EN
  input  logic                  lamp_test_start,
  input  logic [DUR_W-1:0]      lamp_test_dur,
  output logic                  lamp_test_active,
`endif
  output logic [NUM_LEDS-1:0]   led_o,
  output logic [2*NUM_LEDS-1:0] led_state_o
);
  logic tick;
  logic cmd_acc, cmd_bad, cmd_ok;
  logic ready_q, ready_d, err_q, err_d;
  logic [NUM_LEDS-1:0] led_vec;

  led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .ACLK   (ACLK),
    .ARESETN(ARESETN),
    .tick   (tick)
  );

  always_comb begin
    cmd_acc = cmd_valid && ready_q;
    cmd_bad = ({28'd0, cmd_led} >= 32'(NUM_LEDS)) || (cmd_mode == MODE_RSVD);
    cmd_ok  = cmd_acc && !cmd_bad;
    ready_d = 1'b1;
    err_d   = cmd_acc && cmd_bad;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready = ready_q;
  assign cmd_err   = err_q;

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_led
    led_st_e          st_q, st_d;
    logic [DUR_W-1:0] cnt_q, cnt_d, on_q, on_d, off_q, off_d;
    logic             led_q, led_d;
    logic             hit;

    assign hit = cmd_ok && (cmd_led == 4'(i));

    // A command always overrides a same-cycle tick.
    always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      on_d  = on_q;
      off_d = off_q;
      led_d = (st_q == ST_ON) || (st_q == ST_BLK_ON);
      if (hit) begin
        case (cmd_mode)
          MODE_OFF: st_d = ST_OFF;
          MODE_ON:  st_d = ST_ON;
          MODE_BLINK: begin
            on_d  = cmd_on_time;
            off_d = cmd_off_time;
            if (cmd_on_time == '0)       st_d = ST_OFF;
            else if (cmd_off_time == '0) st_d = ST_ON;
            else begin
              st_d  = ST_BLK_ON;
              cnt_d = cmd_on_time;
            end
          end
          default: ;
        endcase
      end else if (tick) begin
        case (st_q)
          ST_BLK_ON: begin
            if (cnt_q == DUR_W'(1)) begin
              st_d  = ST_BLK_OFF;
              cnt_d = off_q;
            end else cnt_d = cnt_q - DUR_W'(1);
          end
          ST_BLK_OFF: begin
            if (cnt_q == DUR_W'(1)) begin
              st_d  = ST_BLK_ON;
              cnt_d = on_q;
            end else cnt_d = cnt_q - DUR_W'(1);
          end
          default: ;
        endcase
      end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
        st_q  <= ST_OFF;
        cnt_q <= '0;
        on_q  <= '0;
        off_q <= '0;
        led_q <= 1'b0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
        on_q  <= on_d;
        off_q <= off_d;
        led_q <= led_d;
      end
    end

    assign led_state_o[2*i +: 2] = st_q;
    assign led_vec[i]            = led_q;
  end

`ifdef LED_LAMP_TEST_EN
  logic [LAMP_W-1:0] lamp_q, lamp_d;

  always_comb begin
    lamp_d = lamp_q;
    if (lamp_test_start && lamp_test_dur != '0)
      lamp_d = LAMP_W'(lamp_test_dur) * LAMP_W'(LAMP_MULT);
    else if (tick && lamp_q != '0)
      lamp_d = lamp_q - LAMP_W'(1);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) lamp_q <= '0;
    else          lamp_q <= lamp_d;
  end

  assign lamp_test_active = (lamp_q != '0);
  assign led_o = (led_vec | {NUM_LEDS{lamp_test_active}}) ^ {NUM_LEDS{ACTIVE_LOW}};
`else
  assign led_o = led_vec ^ {NUM_LEDS{ACTIVE_LOW}};
`endif
endmodule

// File: tb/tb_led_blink_ctrl.sv
// Scoreboard bench for led_blink_ctrl: a cycle model queues expected outputs,
// a negedge checker pops them; directed checks cover latency, blink periods and async reset.
module tb_led_blink_ctrl;
  localparam int NL = 4;
  localparam int TD = 4;

  logic            ACLK = 1'b0;
  logic            ARESETN;
  logic            cmd_valid, cmd_ready, cmd_err;
  logic [3:0]      cmd_led;
  logic [1:0]      cmd_mode;
  logic [7:0]      cmd_on_time, cmd_off_time;
  logic [NL-1:0]   led_o;
  logic [2*NL-1:0] led_state_o;
`ifdef LED_LAMP_TEST_EN
  logic            lamp_test_start, lamp_test_active;
  logic [7:0]      lamp_test_dur;
`endif

  led_blink_ctrl #(.NUM_LEDS(NL), .TICK_DIV(TD), .ACTIVE_LOW(1'b0)) dut (
    .ACLK        (ACLK),
    .ARESETN     (ARESETN),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_led     (cmd_led),
    .cmd_mode    (cmd_mode),
    .cmd_on_time (cmd_on_time),
    .cmd_off_time(cmd_off_time),
    .cmd_err     (cmd_err),
`ifdef LED_LAMP_TEST_EN
    .lamp_test_start (lamp_test_start),
    .lamp_test_dur   (lamp_test_dur),
    .lamp_test_active(lamp_test_active),
`endif
    .led_o       (led_o),
    .led_state_o (led_state_o)
  );

  always #5 ACLK = ~ACLK;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  typedef struct packed {
    logic [NL-1:0]   led;
    logic [2*NL-1:0] st;
    logic            err;
    logic            rdy;
    logic            lamp;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  logic [1:0]    m_st  [NL];
  logic [7:0]    m_cnt [NL];
  logic [7:0]    m_on  [NL];
  logic [7:0]    m_off [NL];
  logic [NL-1:0] m_led;
  logic          m_rdy;
  int            m_pre;
  int            m_lamp;

  // Model temporaries
  logic [1:0]    n_st  [NL];
  logic [7:0]    n_cnt [NL];
  logic [7:0]    n_on  [NL];
  logic [7:0]    n_off [NL];
  logic [NL-1:0] n_led;
  int            n_pre, n_lamp;
  logic          tk, acc, bad;
  exp_t          e_new;

  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      m_st  <= '{default: 2'd0};
      m_cnt <= '{default: 8'd0};
      m_on  <= '{default: 8'd0};
      m_off <= '{default: 8'd0};
      m_led <= '0;
      m_rdy <= 1'b0;
      m_pre <= 0;
      m_lamp <= 0;
      exp_q.delete();
    end else begin
      tk    = (m_pre == TD - 1);
      n_pre = tk ? 0 : m_pre + 1;
      acc   = cmd_valid && m_rdy;
      bad   = (cmd_led >= NL) || (cmd_mode == 2'd3);
      for (int i = 0; i < NL; i++) begin
        n_led[i] = (m_st[i] == 2'd1) || (m_st[i] == 2'd2);
        n_st[i] = m_st[i]; n_cnt[i] = m_cnt[i]; n_on[i] = m_on[i]; n_off[i] = m_off[i];
        if (acc && !bad && cmd_led == 4'(i)) begin
          if (cmd_mode == 2'd0) n_st[i] = 2'd0;
          else if (cmd_mode == 2'd1) n_st[i] = 2'd1;
          else begin
            n_on[i] = cmd_on_time; n_off[i] = cmd_off_time;
            if (cmd_on_time == 0) n_st[i] = 2'd0;
            else if (cmd_off_time == 0) n_st[i] = 2'd1;
            else begin n_st[i] = 2'd2; n_cnt[i] = cmd_on_time; end
          end
        end else if (tk && m_st[i] >= 2'd2) begin
          if (m_cnt[i] != 8'd1) n_cnt[i] = m_cnt[i] - 8'd1;
          else if (m_st[i] == 2'd2) begin n_st[i] = 2'd3; n_cnt[i] = m_off[i]; end
          else begin n_st[i] = 2'd2; n_cnt[i] = m_on[i]; end
        end
      end
      n_lamp = m_lamp;
`ifdef LED_LAMP_TEST_EN
      if (lamp_test_start && lamp_test_dur != 0) n_lamp = int'(lamp_test_dur) * 10;
      else if (tk && m_lamp != 0) n_lamp = m_lamp - 1;
`endif
      e_new.led  = (n_lamp != 0) ? {NL{1'b1}} : n_led;
      for (int i = 0; i < NL; i++) e_new.st[2*i +: 2] = n_st[i];
      e_new.err  = acc && bad;
      e_new.rdy  = 1'b1;
      e_new.lamp = (n_lamp != 0);
      exp_q.push_back(e_new);
      m_st <= n_st; m_cnt <= n_cnt; m_on <= n_on; m_off <= n_off;
      m_led <= n_led; m_rdy <= 1'b1; m_pre <= n_pre; m_lamp <= n_lamp;
    end
  end

  exp_t e_chk;
  always @(negedge ACLK) begin
    if (!ARESETN) begin
      chk("rst_led", 32'(led_o), 0);
      chk("rst_state", 32'(led_state_o), 0);
      chk("rst_ready", 32'(cmd_ready), 0);
      chk("rst_err", 32'(cmd_err), 0);
    end else if (exp_q.size() > 0) begin
      e_chk = exp_q.pop_front();
      chk("sb_led", 32'(led_o), 32'(e_chk.led));
      chk("sb_state", 32'(led_state_o), 32'(e_chk.st));
      chk("sb_err", 32'(cmd_err), 32'(e_chk.err));
      chk("sb_ready", 32'(cmd_ready), 32'(e_chk.rdy));
`ifdef LED_LAMP_TEST_EN
      chk("sb_lamp", 32'(lamp_test_active), 32'(e_chk.lamp));
`endif
    end
  end

  // Drive a command from a negedge; returns at the following negedge.
  task automatic send(input int led, input int mode, input int on_t, input int off_t);
    cmd_valid = 1'b1; cmd_led = 4'(led); cmd_mode = 2'(mode);
    cmd_on_time = 8'(on_t); cmd_off_time = 8'(off_t);
    @(negedge ACLK);
    cmd_valid = 1'b0;
  endtask

  task automatic sync_after_tick();
    int k = 0;
    while (m_pre != 0 && k < 10) begin @(negedge ACLK); k++; end
    if (m_pre != 0) chk("tick_sync_timeout", 0, 1);
  endtask

  int runs[$];
  logic cur;
  int len, k, lamp_cnt;
  logic [2*NL-1:0] snap_st;
  logic [NL-1:0] snap_led;

  initial begin
    ARESETN = 1'b0; cmd_valid = 1'b0; cmd_led = '0; cmd_mode = '0;
    cmd_on_time = '0; cmd_off_time = '0;
`ifdef LED_LAMP_TEST_EN
    lamp_test_start = 1'b0; lamp_test_dur = '0;
`endif
    repeat (3) @(negedge ACLK);
    ARESETN = 1'b1;
    @(posedge ACLK); #1;
    chk("ready_after_release", 32'(cmd_ready), 1);
    chk("led_after_release", 32'(led_o), 0);
    @(negedge ACLK);

    // ON then OFF on LED 2
    send(2, 1, 0, 0);
    chk("on_state", 32'(led_state_o[5:4]), 1);
    chk("on_led_lag", 32'(led_o[2]), 0);
    @(negedge ACLK);
    chk("on_led", 32'(led_o[2]), 1);
    send(2, 0, 0, 0);
    @(negedge ACLK);
    chk("off_led", 32'(led_o[2]), 0);

    // Degenerate and illegal commands
    send(1, 1, 0, 0);
    send(1, 2, 0, 9);
    chk("blink_on0_off", 32'(led_state_o[3:2]), 0);
    send(3, 2, 5, 0);
    chk("blink_off0_on", 32'(led_state_o[7:6]), 1);
    repeat (2) @(negedge ACLK);
    snap_st = led_state_o; snap_led = led_o;
    send(7, 1, 0, 0);
    chk("err_bad_idx", 32'(cmd_err), 1);
    chk("err_idx_state", 32'(led_state_o), 32'(snap_st));
    @(negedge ACLK);
    chk("err_pulse_end", 32'(cmd_err), 0);
    chk("err_idx_led", 32'(led_o), 32'(snap_led));
    send(1, 3, 4, 4);
    chk("err_rsvd_mode", 32'(cmd_err), 1);
    chk("err_rsvd_state", 32'(led_state_o), 32'(snap_st));
    @(negedge ACLK);
    chk("err_rsvd_led", 32'(led_o), 32'(snap_led));

    // BLINK on=3 off=2 on LED 0, accepted the cycle after a tick
    sync_after_tick();
    send(0, 2, 3, 2);
    cur = led_o[0]; len = 1;
    for (int c = 0; c < 140; c++) begin
      @(negedge ACLK);
      chk("blk_code", 32'(led_state_o[1]), 1);
      if (led_o[0] === cur) len++;
      else begin runs.push_back(len); cur = led_o[0]; len = 1; end
    end
    chk("blk_nruns", 32'(runs.size() >= 12), 1);
    if (runs.size() >= 12) begin
      chk("blk_first_phase", 32'(runs[1] >= 9 && runs[1] <= 12), 1);
      for (int r = 2; r < 12; r++)
        chk((r % 2 == 1) ? "blk_hi_len" : "blk_lo_len", 32'(runs[r]), (r % 2 == 1) ? 12 : 8);
    end

    // Override mid-BLK_OFF
    k = 0;
    while (led_state_o[1:0] != 2'd3 && k < 30) begin @(negedge ACLK); k++; end
    chk("wait_blk_off", 32'(led_state_o[1:0]), 3);
    send(0, 1, 0, 0);
    chk("ovr_state", 32'(led_state_o[1:0]), 1);
    @(negedge ACLK);
    chk("ovr_led", 32'(led_o[0]), 1);

`ifdef LED_LAMP_TEST_EN
    send(1, 2, 1, 1);
    sync_after_tick();
    lamp_test_start = 1'b1; lamp_test_dur = 8'd1;
    @(negedge ACLK);
    lamp_test_start = 1'b0;
    lamp_cnt = 0;
    for (int c = 0; c < 50; c++) begin
      if (lamp_test_active && led_o == {NL{1'b1}}) lamp_cnt++;
      @(negedge ACLK);
    end
    chk("lamp_cycles", 32'(lamp_cnt >= 37 && lamp_cnt <= 40), 1);
    chk("lamp_done", 32'(lamp_test_active), 0);
    lamp_test_start = 1'b1; lamp_test_dur = 8'd0;
    @(negedge ACLK);
    lamp_test_start = 1'b0;
    @(negedge ACLK);
    chk("lamp_dur0", 32'(lamp_test_active), 0);
`endif

    // Async reset mid-blink while LED 0 is lit
    send(0, 2, 2, 2);
    k = 0;
    while (led_o[0] !== 1'b1 && k < 30) begin @(negedge ACLK); k++; end
    chk("wait_lit", 32'(led_o[0]), 1);
    @(posedge ACLK); #2;
    ARESETN = 1'b0;
    #1;
    chk("async_rst_led", 32'(led_o), 0);
    chk("async_rst_state", 32'(led_state_o), 0);
    chk("async_rst_ready", 32'(cmd_ready), 0);
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    repeat (4) @(negedge ACLK);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
